// File: rtl/multi_blinker_pkg.sv
// multi_blinker_pkg: shared mode encodings and the channel-index width helper.
package multi_blinker_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    // Width of the channel select: at least one bit even for a single channel.
    function automatic int unsigned ch_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/multi_blinker_channel.sv
// blink_channel: one independent output channel (OFF / ON / BLINK / BURST).
// Holds its own mode, half-period and burst-count registers plus the phase
// and pulse counters; phase counters advance only when tick is high.
module blink_channel
    import multi_blinker_pkg::*;
#(
    parameter int unsigned CNT_W   = 25,
    parameter int unsigned BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [MODE_W-1:0]  mode,
    input  logic [CNT_W-1:0]   half_period,
    input  logic [BURST_W-1:0] burst,
    input  logic               tick,
    output logic               blink,
    output logic               busy,
    output logic               done
);

    mode_e              mode_q,  mode_d;
    logic [CNT_W-1:0]   h_q,     h_d;
    logic [BURST_W-1:0] n_q,     n_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BURST_W-1:0] pulse_q, pulse_d;
    logic               blink_q, blink_d;
    logic               done_q,  done_d;

    // Next state: a load overrides everything (including a burst in flight),
    // otherwise the phase counter steps on tick in BLINK/BURST.
    always_comb begin
        mode_d  = mode_q;
        h_d     = h_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        blink_d = blink_q;
        done_d  = 1'b0;
        if (load) begin
            h_d     = (half_period == '0) ? CNT_W'(1) : half_period;
            n_d     = burst;
            cnt_d   = '0;
            pulse_d = '0;
            case (mode_e'(mode))
                MODE_ON: begin
                    mode_d  = MODE_ON;
                    blink_d = 1'b1;
                end
                MODE_BLINK: begin
                    mode_d  = MODE_BLINK;
                    blink_d = 1'b1;
                end
                MODE_BURST: begin
                    // A zero-length burst is indistinguishable from OFF.
                    if (burst == '0) begin
                        mode_d  = MODE_OFF;
                        blink_d = 1'b0;
                    end else begin
                        mode_d  = MODE_BURST;
                        blink_d = 1'b1;
                    end
                end
                default: begin
                    mode_d  = MODE_OFF;
                    blink_d = 1'b0;
                end
            endcase
        end else if (tick && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
            if (cnt_q == h_q - CNT_W'(1)) begin
                cnt_d   = '0;
                blink_d = !blink_q;
                // Pulses are counted on the high-to-low phase boundary.
                if (mode_q == MODE_BURST && blink_q) begin
                    if (pulse_q == n_q - BURST_W'(1)) begin
                        mode_d  = MODE_OFF;
                        blink_d = 1'b0;
                        done_d  = 1'b1;
                        pulse_d = '0;
                    end else begin
                        pulse_d = pulse_q + BURST_W'(1);
                    end
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            h_q     <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            pulse_q <= '0;
            blink_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            h_q     <= h_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            blink_q <= blink_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from flops; busy is the registered BURST mode.
    always_comb begin
        blink = blink_q;
        busy  = (mode_q == MODE_BURST);
        done  = done_q;
    end

endmodule

// File: rtl/multi_blinker.sv
// multi_blinker: multi-channel LED blinker with a valid/ready config port.
// Optional build macro MULTI_BLINKER_PRESCALE_EN adds a shared prescaler
// (parameter PRESCALE) so half-periods are counted in prescaler ticks.
module multi_blinker
    import multi_blinker_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 25,
    parameter int unsigned BURST_W  = 4
`ifdef MULTI_BLINKER_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE = 1000
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ch_width(CHANNELS)-1:0] cfg_ch,
    input  logic [MODE_W-1:0]             cfg_mode,
    input  logic [CNT_W-1:0]              cfg_half_period,
    input  logic [BURST_W-1:0]            cfg_burst,
    output logic [CHANNELS-1:0]           blink,
    output logic [CHANNELS-1:0]           busy,
    output logic [CHANNELS-1:0]           done
);

    localparam int unsigned CH_W = ch_width(CHANNELS);

    logic cfg_ready_q, cfg_ready_d;
    logic accept;
    logic tick;

    // Handshake: ready drops for exactly one cycle after each accept.
    always_comb begin
        accept      = cfg_valid && cfg_ready_q;
        cfg_ready_d = !accept;
        cfg_ready   = cfg_ready_q;
    end

    // Ready register; reset leaves the port ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ready_q <= 1'b1;
        end else begin
            cfg_ready_q <= cfg_ready_d;
        end
    end

`ifdef MULTI_BLINKER_PRESCALE_EN
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;

    // Free-running prescaler: one tick on the last count of every period.
    always_comb begin
        tick  = (pre_q == PRE_W'(PRESCALE - 1));
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    // Prescaler register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    // Without the prescaler every clock is a counting cycle.
    always_comb begin
        tick = 1'b1;
    end
`endif

    // Select values that match no channel are accepted and simply dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic load;

        // Per-channel load strobe from the channel-select decode.
        always_comb begin
            load = accept && (cfg_ch == CH_W'(i));
        end

        blink_channel #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_channel (
            .clk         (clk),
            .rst_n       (rst_n),
            .load        (load),
            .mode        (cfg_mode),
            .half_period (cfg_half_period),
            .burst       (cfg_burst),
            .tick        (tick),
            .blink       (blink[i]),
            .busy        (busy[i]),
            .done        (done[i])
        );
    end

endmodule

// File: tb/tb_multi_blinker.sv
// tb_multi_blinker: directed plus randomized bench for multi_blinker with a
// per-channel reference model expressed as elapsed-time arithmetic.
module tb_multi_blinker;

    localparam int CH  = 5;
    localparam int CW  = 8;
    localparam int BW  = 4;
    localparam int CHW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch = '0;
    logic [1:0]     cfg_mode = '0;
    logic [CW-1:0]  cfg_half_period = '0;
    logic [BW-1:0]  cfg_burst = '0;
    logic [CH-1:0]  blink, busy, done;

    multi_blinker #(
        .CHANNELS (CH),
        .CNT_W    (CW),
        .BURST_W  (BW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_ch          (cfg_ch),
        .cfg_mode        (cfg_mode),
        .cfg_half_period (cfg_half_period),
        .cfg_burst       (cfg_burst),
        .blink           (blink),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel remembers its last applied mode, H, N and the cycle its
    // output started; outputs are derived from the elapsed cycle count.
    int unsigned cyc = 0;
    int unsigned m_mode [CH];
    int unsigned m_h    [CH];
    int unsigned m_n    [CH];
    int unsigned m_t0   [CH];
    bit          m_ready = 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_ready <= 1'b1;
            for (int i = 0; i < CH; i++) m_mode[i] <= 0;
        end else begin
            m_ready <= !(cfg_valid && m_ready);
            if (cfg_valid && m_ready && int'(cfg_ch) < CH) begin
                m_mode[cfg_ch] <= cfg_mode;
                m_h[cfg_ch]    <= (cfg_half_period == 0) ? 1 : int'(cfg_half_period);
                m_n[cfg_ch]    <= cfg_burst;
                m_t0[cfg_ch]   <= cyc + 1;
            end
        end
    end

    function automatic void model_ch(input int i, output logic b, output logic bu, output logic d);
        int unsigned k;
        int unsigned h;
        int unsigned n;
        k  = cyc - m_t0[i];
        h  = m_h[i];
        n  = m_n[i];
        b  = 1'b0;
        bu = 1'b0;
        d  = 1'b0;
        case (m_mode[i])
            1: b = 1'b1;
            2: b = ((k / h) % 2 == 0);
            3: if (n != 0) begin
                if (k < (2 * n - 1) * h) begin
                    b  = ((k / h) % 2 == 0);
                    bu = 1'b1;
                end else if (k == (2 * n - 1) * h) begin
                    d = 1'b1;
                end
            end
            default: ;
        endcase
    endfunction

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [CH-1:0] eb, ebu, ed;
            for (int i = 0; i < CH; i++) model_ch(i, eb[i], ebu[i], ed[i]);
            check("model_blink", 32'(blink), 32'(eb));
            check("model_busy", 32'(busy), 32'(ebu));
            check("model_done", 32'(done), 32'(ed));
            check("model_ready", 32'(cfg_ready), 32'(m_ready));
        end
    end

    // ---------------- stimulus ----------------
    // Called on a negedge; returns on the negedge of the first cycle after accept.
    task automatic cfg_write(input int ch, input int mode, input int h, input int n);
        int w;
        w = 0;
        while (cfg_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (w >= 10) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_wait: got cfg_ready=%b expected 1 within 10 cycles", cfg_ready);
        end
        cfg_valid       = 1'b1;
        cfg_ch          = CHW'(ch);
        cfg_mode        = 2'(mode);
        cfg_half_period = CW'(h);
        cfg_burst       = BW'(n);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    logic [11:0] pat_blink;
    logic [11:0] pat_bb, pat_bu, pat_bd;
    logic [5:0]  pat_h0;

    initial begin
        pat_blink = 12'h1C7;   // H=3: 1,1,1,0,0,0 repeating
        pat_bb    = 12'h333;   // H=2,N=3 burst: high on 0-1,4-5,8-9
        pat_bu    = 12'h3FF;   // busy on 0-9
        pat_bd    = 12'h400;   // done only on 10
        pat_h0    = 6'b010101; // H=0 treated as 1: toggles every cycle

        // Reset held 3 cycles with a pending request that must be ignored.
        rst_n     = 1'b0;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_mode  = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_en = 1'b1;
            check("rst_blink", 32'(blink), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_ready", 32'(cfg_ready), 1);
        end
        cfg_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("post_rst_blink", 32'(blink), 0);

        // BLINK ch0 H=3.
        cfg_write(0, 2, 3, 0);
        for (int k = 0; k < 12; k++) begin
            check("blink_h3", 32'(blink[0]), 32'(pat_blink[k]));
            check("blink_others", 32'(blink[4:1]), 0);
            @(negedge clk);
        end
        cfg_write(0, 0, 0, 0);
        @(negedge clk);

        // BURST ch2 H=2 N=3.
        cfg_write(2, 3, 2, 3);
        for (int k = 0; k < 12; k++) begin
            check("burst_blink", 32'(blink[2]), 32'(pat_bb[k]));
            check("burst_busy", 32'(busy[2]), 32'(pat_bu[k]));
            check("burst_done", 32'(done[2]), 32'(pat_bd[k]));
            @(negedge clk);
        end

        // Handshake: valid held 4 cycles, ch1 ON then ch1 OFF.
        check("hs_ready_c0", 32'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_mode  = 2'd1;
        @(negedge clk);
        check("hs_ready_c1", 32'(cfg_ready), 0);
        check("hs_blink_c1", 32'(blink[1]), 1);
        cfg_mode = 2'd0;
        @(negedge clk);
        check("hs_ready_c2", 32'(cfg_ready), 1);
        check("hs_blink_c2", 32'(blink[1]), 1);
        @(negedge clk);
        check("hs_ready_c3", 32'(cfg_ready), 0);
        check("hs_blink_c3", 32'(blink[1]), 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        check("hs_ready_c4", 32'(cfg_ready), 1);
        check("hs_blink_c4", 32'(blink[1]), 0);

        // Abort: ch2 BURST H=4 N=5, rewritten to ON at cycle 6.
        cfg_write(2, 3, 4, 5);
        check("abort_blink_c0", 32'(blink[2]), 1);
        check("abort_busy_c0", 32'(busy[2]), 1);
        repeat (6) @(negedge clk);
        check("abort_blink_c6", 32'(blink[2]), 0);
        check("abort_busy_c6", 32'(busy[2]), 1);
        cfg_write(2, 1, 0, 0);
        for (int k = 0; k < 40; k++) begin
            check("abort_blink", 32'(blink[2]), 1);
            check("abort_busy", 32'(busy[2]), 0);
            check("abort_done", 32'(done[2]), 0);
            @(negedge clk);
        end

        // H=0 BLINK on ch3 toggles every cycle.
        cfg_write(3, 2, 0, 0);
        for (int k = 0; k < 6; k++) begin
            check("h0_blink", 32'(blink[3]), 32'(pat_h0[k]));
            @(negedge clk);
        end
        cfg_write(3, 0, 0, 0);

        // BURST with N=0 on ch4 (previously ON) behaves as OFF.
        cfg_write(4, 1, 0, 0);
        check("n0_pre_on", 32'(blink[4]), 1);
        @(negedge clk);
        cfg_write(4, 3, 2, 0);
        for (int k = 0; k < 6; k++) begin
            check("n0_blink", 32'(blink[4]), 0);
            check("n0_busy", 32'(busy[4]), 0);
            check("n0_done", 32'(done[4]), 0);
            @(negedge clk);
        end

        // Out-of-range channel select: accepted, nothing changes.
        cfg_write(1, 1, 0, 0);
        @(negedge clk);
        cfg_write(5, 0, 0, 0);
        check("oor_ready", 32'(cfg_ready), 0);
        check("oor_blink", 32'(blink), 32'(5'b00110));
        check("oor_busy", 32'(busy), 0);
        @(negedge clk);
        cfg_write(7, 0, 0, 0);
        check("oor7_blink", 32'(blink), 32'(5'b00110));

        // Reset mid-burst: burst aborted, no done strobe.
        @(negedge clk);
        cfg_write(0, 3, 3, 2);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_blink", 32'(blink), 0);
        check("midrst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("midrst_done", 32'(done), 0);
        end

        // Randomized traffic including occasional resets.
        for (int k = 0; k < 2000; k++) begin
            rst_n           = ($urandom_range(0, 299) != 0);
            cfg_valid       = ($urandom_range(0, 3) == 0);
            cfg_ch          = CHW'($urandom_range(0, 7));
            cfg_mode        = 2'($urandom_range(0, 3));
            cfg_half_period = CW'($urandom_range(0, 4));
            cfg_burst       = BW'($urandom_range(0, 3));
            @(negedge clk);
        end
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 2000000");
        $fatal(1, "watchdog");
    end

endmodule
